// File: rtl/shift_unit_seq.sv
// Sequential barrel shifter: one log2 stage per clock (SLL/SRL/SRA/ROR).
// A start is accepted only while idle; the result, carry and zero flags then hold until the next completion.
module shift_unit_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero
);

  localparam logic [1:0]     M_SLL  = 2'b00;
  localparam logic [1:0]     M_SRL  = 2'b01;
  localparam logic [1:0]     M_SRA  = 2'b10;
  localparam logic [SHW-1:0] K_ONE  = SHW'(1);
  localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [SHW-1:0]   k;
  logic             cap_en, step_en, last;

  logic [WIDTH-1:0] a_cap;
  logic [SHW-1:0]   b_cap;
  logic [1:0]       mode_cap;
  logic [WIDTH-1:0] w, w_nxt;

  // One stage: shift by 2^k. SRA keeps the sign because every earlier
  // SRA stage already replicated the original MSB into the top bit.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] wv,
                                                   input logic [SHW-1:0]   ks,
                                                   input logic [1:0]       m);
    logic [SHW-1:0]          amt;
    logic signed [WIDTH-1:0] ws;
    logic [2*WIDTH-1:0]      dbl;
    amt = K_ONE << ks;
    ws  = $signed(wv);
    dbl = {wv, wv} >> amt;
    case (m)
      M_SLL:   shift_stage = wv << amt;
      M_SRL:   shift_stage = wv >> amt;
      M_SRA:   shift_stage = $unsigned(ws >>> amt);
      default: shift_stage = dbl[WIDTH-1:0];
    endcase
  endfunction

  // Last bit shifted out, derived from the captured operand and amount.
  function automatic logic carry_out(input logic [WIDTH-1:0] a,
                                     input logic [SHW-1:0]   n,
                                     input logic [1:0]       m,
                                     input logic [WIDTH-1:0] r);
    logic [SHW-1:0]   nm1;
    logic [WIDTH-1:0] up, dn;
    nm1 = n - K_ONE;
    up  = a << nm1;
    dn  = a >> nm1;
    if (n == '0) begin
      carry_out = 1'b0;
    end else begin
      case (m)
        M_SLL:        carry_out = up[WIDTH-1];
        M_SRL, M_SRA: carry_out = dn[0];
        default:      carry_out = r[WIDTH-1];
      endcase
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cap_en  = 1'b0;
    step_en = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cap_en  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        step_en = 1'b1;
        if (k == K_LAST) begin
          last    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy  = (state == SHIFT);
  assign w_nxt = b_cap[k] ? shift_stage(w, k, mode_cap) : w;

  always_ff @(posedge clk) begin
    if (rst) begin
      k    <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (cap_en)       k <= '0;
      else if (step_en) k <= k + K_ONE;
    end
  end

  // Capture and working datapath: no reset, qualified by control only.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      a_cap    <= A;
      b_cap    <= B;
      mode_cap <= mode;
      w        <= A;
    end else if (step_en) begin
      w <= w_nxt;
    end
  end

  // Completion: publish result and flags together.
  always_ff @(posedge clk) begin
    if (rst) begin
      res   <= '0;
      carry <= 1'b0;
      zero  <= 1'b1;
    end else if (last) begin
      res   <= w_nxt;
      carry <= carry_out(a_cap, b_cap, mode_cap, w_nxt);
      zero  <= (w_nxt == '0);
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Randomized bench for shift_unit_seq (WIDTH=8) against an arithmetic reference model.
module tb_shift_unit_seq;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] mode;
  logic [7:0] A;
  logic [2:0] B;
  logic       busy, done, carry, zero;
  logic [7:0] res;

  int ntests = 0;
  int nfail  = 0;
  int last_res = 0, last_carry = 0, last_zero = 1;

  shift_unit_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .A(A), .B(B),
    .busy(busy), .done(done), .res(res), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-operation result straight from the mode definitions.
  function automatic void model(input int a, input int n, input int m,
                                output int r, output int c);
    int sa;
    case (m)
      0: begin r = (a << n) & 255; c = (n == 0) ? 0 : (a >> (8 - n)) & 1; end
      1: begin r = a >> n;         c = (n == 0) ? 0 : (a >> (n - 1)) & 1; end
      2: begin
        sa = (a >= 128) ? a - 256 : a;
        r  = (sa >>> n) & 255;
        c  = (n == 0) ? 0 : (a >> (n - 1)) & 1;
      end
      default: begin
        r = ((a >> n) | (a << (8 - n))) & 255;
        c = (n == 0) ? 0 : (r >> 7) & 1;
      end
    endcase
  endfunction

  // Entered and left at a negedge; leaves inside the done cycle so a
  // following call starts back-to-back.
  task automatic do_op(input int a, input int n, input int m, input bit noisy);
    int er, ec;
    model(a, n, m, er, ec);
    A = 8'(a); B = 3'(n); mode = 2'(m); start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("res_hold", res, last_res);
      if (noisy) begin
        A = 8'($urandom); B = 3'($urandom); mode = 2'($urandom); start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("res", res, er);
    chk("carry", carry, ec);
    chk("zero", zero, (er == 0));
    last_res = er; last_carry = ec; last_zero = (er == 0);
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_res", res, last_res);
    chk("idle_carry", carry, last_carry);
    chk("idle_zero", zero, last_zero);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; A = 8'h00; B = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 1);
    rst = 1'b0;
    idle_cycle();

    // Directed vectors
    do_op(8'hB4, 3, 1, 0); idle_cycle();
    chk("dir_srl_res", res, 8'h16);
    do_op(8'h80, 7, 2, 0); idle_cycle();
    chk("dir_sra_res", res, 8'hFF);
    do_op(8'h81, 1, 0, 0); idle_cycle();
    do_op(8'h01, 1, 3, 0); idle_cycle();
    chk("dir_ror_res", res, 8'h80);
    do_op(8'h5A, 0, 1, 0); idle_cycle();
    do_op(8'h0F, 4, 1, 0);
    do_op(8'h03, 2, 0, 0); idle_cycle();
    chk("dir_b2b_res", res, 8'h0C);

    // Start held during busy with changing inputs: single completion
    do_op(8'hFF, 5, 2, 1); idle_cycle(); idle_cycle();

    // Reset mid-operation aborts with no done pulse
    A = 8'h37; B = 3'd6; mode = 2'b11; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", res, 0);
    chk("abort_zero", zero, 1);
    chk("abort_carry", carry, 0);
    last_res = 0; last_carry = 0; last_zero = 1;
    repeat (4) idle_cycle();

    // Reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; A = 8'hAA; B = 3'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", busy, 0);
    repeat (4) idle_cycle();

    // Random operations, mixing back-to-back and idle gaps
    for (int t = 0; t < 60; t++) begin
      do_op(int'($urandom_range(255)), int'($urandom_range(7)),
            int'($urandom_range(3)), bit'($urandom_range(1)));
      if ($urandom_range(2) != 0) idle_cycle();
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
